// File: rtl/cpu_pkg.sv
// Shared encodings for the execute stage: ALU control codes, ALUOp values,
// R-type funct constants and default datapath widths.
package cpu_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_MUL = 3'b111
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_OR    = 2'b11
  } alu_op_e;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_MUL = 6'b011000;

endpackage

// File: rtl/fwd_mux.sv
// Per-operand forwarding select: EX/MEM beats MEM/WB, register 0 never forwards.
module fwd_mux
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] src_addr,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              exmem_we,
  input  logic [REG_AW-1:0] exmem_addr,
  input  logic [DATA_W-1:0] exmem_data,
  input  logic              memwb_we,
  input  logic [REG_AW-1:0] memwb_addr,
  input  logic [DATA_W-1:0] memwb_data,
  output logic [DATA_W-1:0] fwd_data
);

  logic exmem_hit;
  logic memwb_hit;

  assign exmem_hit = exmem_we && (exmem_addr != '0) && (exmem_addr == src_addr);
  assign memwb_hit = memwb_we && (memwb_addr != '0) && (memwb_addr == src_addr);

  always_comb begin
    fwd_data = reg_data;
    if (exmem_hit) begin
      fwd_data = exmem_data;
    end else if (memwb_hit) begin
      fwd_data = memwb_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX front end: operand forwarding, immediate
// select, ALU control decode and load-use hazard detection.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              hold_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] RSdata_i,
  input  logic [DATA_W-1:0] RTdata_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [REG_AW-1:0] RSaddr_i,
  input  logic [REG_AW-1:0] RTaddr_i,
  input  logic [REG_AW-1:0] RDaddr_i,
  input  logic [5:0]        funct_i,
  input  logic [1:0]        ALUOp_i,
  input  logic              ALUSrc_i,
  input  logic              RegDst_i,
  input  logic              RegWrite_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic              MemtoReg_i,
  input  logic              EXMEM_RegWrite_i,
  input  logic [REG_AW-1:0] EXMEM_RDaddr_i,
  input  logic [DATA_W-1:0] EXMEM_data_i,
  input  logic              MEMWB_RegWrite_i,
  input  logic [REG_AW-1:0] MEMWB_RDaddr_i,
  input  logic [DATA_W-1:0] MEMWB_data_i,
  output logic [DATA_W-1:0] data1_o,
  output logic [DATA_W-1:0] data2_o,
  output logic [2:0]        ALUCtrl_o,
  output logic [DATA_W-1:0] STdata_o,
  output logic [REG_AW-1:0] RDaddr_o,
  output logic              RegWrite_o,
  output logic              MemRead_o,
  output logic              MemWrite_o,
  output logic              MemtoReg_o,
  output logic              valid_o,
  output logic              hazard_o
);

  function automatic logic [2:0] alu_decode(input logic [1:0] op, input logic [5:0] fn);
    logic [2:0] code;
    code = ALU_ADD;
    case (op)
      ALUOP_ADD: code = ALU_ADD;
      ALUOP_SUB: code = ALU_SUB;
      ALUOP_OR:  code = ALU_OR;
      default: begin
        case (fn)
          FUNCT_ADD: code = ALU_ADD;
          FUNCT_SUB: code = ALU_SUB;
          FUNCT_AND: code = ALU_AND;
          FUNCT_OR:  code = ALU_OR;
          FUNCT_MUL: code = ALU_MUL;
          default:   code = ALU_ADD;
        endcase
      end
    endcase
    return code;
  endfunction

  logic [DATA_W-1:0] rs_data_p1;
  logic [DATA_W-1:0] rt_data_p1;
  logic [DATA_W-1:0] imm_p1;
  logic [REG_AW-1:0] rs_addr_p1;
  logic [REG_AW-1:0] rt_addr_p1;
  logic [REG_AW-1:0] rd_addr_p1;
  logic [5:0]        funct_p1;
  logic [1:0]        alu_op_p1;
  logic              alu_src_p1;
  logic              reg_dst_p1;
  logic              reg_write_p1;
  logic              mem_read_p1;
  logic              mem_write_p1;
  logic              mem_to_reg_p1;
  logic              vld_p1;

  logic              hazard;
  logic              load_bubble;
  logic              capture;
  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;

  // A load in EX whose target is read by the instruction now in ID must stall it.
  assign hazard = vld_p1 && mem_read_p1 && (rt_addr_p1 != '0) &&
                  ((rt_addr_p1 == RSaddr_i) || (rt_addr_p1 == RTaddr_i));

  assign load_bubble = rst_i || flush_i || (!hold_i && hazard);
  assign capture     = !hold_i && !hazard;

  // ---- ID -> EX register boundary ----
  always_ff @(posedge clk_i) begin
    if (load_bubble) begin
      rs_data_p1    <= '0;
      rt_data_p1    <= '0;
      imm_p1        <= '0;
      rs_addr_p1    <= '0;
      rt_addr_p1    <= '0;
      rd_addr_p1    <= '0;
      funct_p1      <= '0;
      alu_op_p1     <= '0;
      alu_src_p1    <= 1'b0;
      reg_dst_p1    <= 1'b0;
      reg_write_p1  <= 1'b0;
      mem_read_p1   <= 1'b0;
      mem_write_p1  <= 1'b0;
      mem_to_reg_p1 <= 1'b0;
      vld_p1        <= 1'b0;
    end else if (capture) begin
      rs_data_p1    <= RSdata_i;
      rt_data_p1    <= RTdata_i;
      imm_p1        <= imm_i;
      rs_addr_p1    <= RSaddr_i;
      rt_addr_p1    <= RTaddr_i;
      rd_addr_p1    <= RDaddr_i;
      funct_p1      <= funct_i;
      alu_op_p1     <= ALUOp_i;
      alu_src_p1    <= ALUSrc_i;
      reg_dst_p1    <= RegDst_i;
      reg_write_p1  <= RegWrite_i;
      mem_read_p1   <= MemRead_i;
      mem_write_p1  <= MemWrite_i;
      mem_to_reg_p1 <= MemtoReg_i;
      vld_p1        <= 1'b1;
    end
  end

  // ---- EX front end (combinational from registered fields) ----
  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_a (
    .src_addr   (rs_addr_p1),
    .reg_data   (rs_data_p1),
    .exmem_we   (EXMEM_RegWrite_i),
    .exmem_addr (EXMEM_RDaddr_i),
    .exmem_data (EXMEM_data_i),
    .memwb_we   (MEMWB_RegWrite_i),
    .memwb_addr (MEMWB_RDaddr_i),
    .memwb_data (MEMWB_data_i),
    .fwd_data   (fwd_a)
  );

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_b (
    .src_addr   (rt_addr_p1),
    .reg_data   (rt_data_p1),
    .exmem_we   (EXMEM_RegWrite_i),
    .exmem_addr (EXMEM_RDaddr_i),
    .exmem_data (EXMEM_data_i),
    .memwb_we   (MEMWB_RegWrite_i),
    .memwb_addr (MEMWB_RDaddr_i),
    .memwb_data (MEMWB_data_i),
    .fwd_data   (fwd_b)
  );

  assign data1_o    = fwd_a;
  assign STdata_o   = fwd_b;
  assign data2_o    = alu_src_p1 ? imm_p1 : fwd_b;
  assign RDaddr_o   = reg_dst_p1 ? rd_addr_p1 : rt_addr_p1;
  assign ALUCtrl_o  = alu_decode(alu_op_p1, funct_p1);
  assign RegWrite_o = reg_write_p1;
  assign MemRead_o  = mem_read_p1;
  assign MemWrite_o = mem_write_p1;
  assign MemtoReg_o = mem_to_reg_p1;
  assign valid_o    = vld_p1;
  assign hazard_o   = hazard;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed table-driven bench for id_ex_stage plus hand sequences for
// reset, load-use, hold and flush behaviour.
module tb_id_ex_stage;

  typedef struct {
    logic [31:0] rsd, rtd, imm;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  funct;
    logic [1:0]  aluop;
    logic        alusrc, regdst, rw, mr, mw, m2r;
    logic        exw;
    logic [4:0]  exa;
    logic [31:0] exd;
    logic        mww;
    logic [4:0]  mwa;
    logic [31:0] mwd;
    logic [31:0] e_d1, e_d2, e_st;
    logic [2:0]  e_alu;
    logic [4:0]  e_rd;
    logic [3:0]  e_ctl;
    logic        e_vld, e_haz;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, hold, flush;
  logic [31:0] rs_data, rt_data, imm;
  logic [4:0]  rs_addr, rt_addr, rd_addr;
  logic [5:0]  funct;
  logic [1:0]  alu_op;
  logic        alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg;
  logic        exmem_we, memwb_we;
  logic [4:0]  exmem_addr, memwb_addr;
  logic [31:0] exmem_data, memwb_data;
  logic [31:0] data1, data2, st_data;
  logic [2:0]  alu_ctrl;
  logic [4:0]  rd_out;
  logic        rw_out, mr_out, mw_out, m2r_out, valid, hazard;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk_i(clk), .rst_i(rst), .hold_i(hold), .flush_i(flush),
    .RSdata_i(rs_data), .RTdata_i(rt_data), .imm_i(imm),
    .RSaddr_i(rs_addr), .RTaddr_i(rt_addr), .RDaddr_i(rd_addr),
    .funct_i(funct), .ALUOp_i(alu_op), .ALUSrc_i(alu_src), .RegDst_i(reg_dst),
    .RegWrite_i(reg_write), .MemRead_i(mem_read), .MemWrite_i(mem_write),
    .MemtoReg_i(mem_to_reg),
    .EXMEM_RegWrite_i(exmem_we), .EXMEM_RDaddr_i(exmem_addr), .EXMEM_data_i(exmem_data),
    .MEMWB_RegWrite_i(memwb_we), .MEMWB_RDaddr_i(memwb_addr), .MEMWB_data_i(memwb_data),
    .data1_o(data1), .data2_o(data2), .ALUCtrl_o(alu_ctrl), .STdata_o(st_data),
    .RDaddr_o(rd_out), .RegWrite_o(rw_out), .MemRead_o(mr_out), .MemWrite_o(mw_out),
    .MemtoReg_o(m2r_out), .valid_o(valid), .hazard_o(hazard)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t zv();
    vec_t z;
    z = '{default: '0};
    z.e_alu = 3'b010;
    z.e_vld = 1'b1;
    return z;
  endfunction

  task automatic drive(input vec_t v);
    rs_data = v.rsd; rt_data = v.rtd; imm = v.imm;
    rs_addr = v.rs; rt_addr = v.rt; rd_addr = v.rd;
    funct = v.funct; alu_op = v.aluop; alu_src = v.alusrc; reg_dst = v.regdst;
    reg_write = v.rw; mem_read = v.mr; mem_write = v.mw; mem_to_reg = v.m2r;
    exmem_we = v.exw; exmem_addr = v.exa; exmem_data = v.exd;
    memwb_we = v.mww; memwb_addr = v.mwa; memwb_data = v.mwd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, " valid"}, 32'(valid), 32'h0);
    chk({tag, " ctl"}, 32'({rw_out, mr_out, mw_out, m2r_out}), 32'h0);
    chk({tag, " aluctrl"}, 32'(alu_ctrl), 32'h2);
    chk({tag, " data1"}, data1, 32'h0);
    chk({tag, " data2"}, data2, 32'h0);
    chk({tag, " rdaddr"}, 32'(rd_out), 32'h0);
  endtask

  vec_t v[15];
  vec_t w, u, x;

  initial begin
    for (int i = 0; i < 15; i++) v[i] = zv();
    v[0].rsd = 15; v[0].rtd = 5; v[0].rs = 1; v[0].rt = 2; v[0].rd = 7;
    v[0].funct = 6'b100010; v[0].aluop = 2'b10; v[0].regdst = 1; v[0].rw = 1;
    v[0].e_d1 = 15; v[0].e_d2 = 5; v[0].e_st = 5; v[0].e_alu = 3'b110; v[0].e_rd = 7; v[0].e_ctl = 4'b1000;

    v[1].rsd = 32'hF0F0; v[1].rtd = 32'h0FF0; v[1].rs = 3; v[1].rt = 4; v[1].rd = 9;
    v[1].funct = 6'b100100; v[1].aluop = 2'b10; v[1].rw = 1;
    v[1].e_d1 = 32'hF0F0; v[1].e_d2 = 32'h0FF0; v[1].e_st = 32'h0FF0; v[1].e_alu = 3'b000; v[1].e_rd = 4; v[1].e_ctl = 4'b1000;

    v[2].rsd = 1; v[2].rtd = 2; v[2].rs = 5; v[2].rt = 6; v[2].rd = 11;
    v[2].funct = 6'b100101; v[2].aluop = 2'b10; v[2].regdst = 1;
    v[2].e_d1 = 1; v[2].e_d2 = 2; v[2].e_st = 2; v[2].e_alu = 3'b001; v[2].e_rd = 11;

    v[3].rsd = 3; v[3].rtd = 4; v[3].rs = 7; v[3].rt = 8; v[3].rd = 12;
    v[3].funct = 6'b011000; v[3].aluop = 2'b10; v[3].regdst = 1; v[3].rw = 1;
    v[3].e_d1 = 3; v[3].e_d2 = 4; v[3].e_st = 4; v[3].e_alu = 3'b111; v[3].e_rd = 12; v[3].e_ctl = 4'b1000;

    v[4].rsd = 32'hA; v[4].rtd = 32'hB; v[4].rs = 2; v[4].rt = 3; v[4].rd = 13;
    v[4].funct = 6'b111111; v[4].aluop = 2'b10; v[4].regdst = 1;
    v[4].e_d1 = 32'hA; v[4].e_d2 = 32'hB; v[4].e_st = 32'hB; v[4].e_alu = 3'b010; v[4].e_rd = 13;

    v[5].rsd = 32'h40; v[5].rtd = 32'h99; v[5].rs = 1; v[5].rt = 6; v[5].imm = 32'hFFFF_FFF8;
    v[5].funct = 6'b100010; v[5].aluop = 2'b00; v[5].alusrc = 1; v[5].mw = 1;
    v[5].exw = 1; v[5].exa = 6; v[5].exd = 32'h1234;
    v[5].e_d1 = 32'h40; v[5].e_d2 = 32'hFFFF_FFF8; v[5].e_st = 32'h1234; v[5].e_rd = 6; v[5].e_ctl = 4'b0010;

    v[6].rsd = 32'h20; v[6].rtd = 32'h20; v[6].rs = 8; v[6].rt = 9; v[6].funct = 6'b100100; v[6].aluop = 2'b01;
    v[6].e_d1 = 32'h20; v[6].e_d2 = 32'h20; v[6].e_st = 32'h20; v[6].e_alu = 3'b110; v[6].e_rd = 9;

    v[7].rsd = 3; v[7].rtd = 4; v[7].rs = 1; v[7].rt = 2; v[7].aluop = 2'b11; v[7].alusrc = 1; v[7].imm = 7;
    v[7].rw = 1; v[7].m2r = 1;
    v[7].e_d1 = 3; v[7].e_d2 = 7; v[7].e_st = 4; v[7].e_alu = 3'b001; v[7].e_rd = 2; v[7].e_ctl = 4'b1001;

    v[8].rsd = 32'h11; v[8].rtd = 32'h22; v[8].rs = 3; v[8].rt = 10;
    v[8].exw = 1; v[8].exa = 3; v[8].exd = 32'hAA; v[8].mww = 1; v[8].mwa = 3; v[8].mwd = 32'hBB;
    v[8].e_d1 = 32'hAA; v[8].e_d2 = 32'h22; v[8].e_st = 32'h22; v[8].e_rd = 10;

    v[9] = v[8]; v[9].exw = 0; v[9].e_d1 = 32'hBB;

    v[10].rsd = 32'h55; v[10].rtd = 32'h66;
    v[10].exw = 1; v[10].exa = 0; v[10].exd = 32'hAA; v[10].mww = 1; v[10].mwa = 0; v[10].mwd = 32'hBB;
    v[10].e_d1 = 32'h55; v[10].e_d2 = 32'h66; v[10].e_st = 32'h66;

    v[11].rsd = 1; v[11].rtd = 2; v[11].rs = 4; v[11].rt = 5;
    v[11].exw = 1; v[11].exa = 5; v[11].exd = 32'hEE; v[11].mww = 1; v[11].mwa = 5; v[11].mwd = 32'hCC;
    v[11].e_d1 = 1; v[11].e_d2 = 32'hEE; v[11].e_st = 32'hEE; v[11].e_rd = 5;

    v[12] = v[11]; v[12].exa = 9; v[12].e_d2 = 32'hCC; v[12].e_st = 32'hCC;

    v[13] = v[11]; v[13].exw = 0; v[13].mww = 0; v[13].e_d2 = 2; v[13].e_st = 2;

    v[14].rsd = 32'h77; v[14].alusrc = 1; v[14].imm = 4; v[14].mr = 1; v[14].rw = 1; v[14].m2r = 1;
    v[14].e_d1 = 32'h77; v[14].e_d2 = 4; v[14].e_ctl = 4'b1101;

    // Reset with arbitrary, hazard-provoking inputs
    hold = 0; flush = 0; rst = 1;
    w = v[0]; w.mr = 1; w.rs = 4; w.rt = 4;
    drive(w);
    for (int c = 0; c < 2; c++) begin
      step();
      chk_bubble($sformatf("reset%0d", c));
      chk($sformatf("reset%0d hazard", c), 32'(hazard), 32'h0);
    end
    rst = 0;

    for (int i = 0; i < 15; i++) begin
      drive(v[i]);
      step();
      chk($sformatf("row%0d data1", i), data1, v[i].e_d1);
      chk($sformatf("row%0d data2", i), data2, v[i].e_d2);
      chk($sformatf("row%0d stdata", i), st_data, v[i].e_st);
      chk($sformatf("row%0d aluctrl", i), 32'(alu_ctrl), 32'(v[i].e_alu));
      chk($sformatf("row%0d rdaddr", i), 32'(rd_out), 32'(v[i].e_rd));
      chk($sformatf("row%0d ctl", i), 32'({rw_out, mr_out, mw_out, m2r_out}), 32'(v[i].e_ctl));
      chk($sformatf("row%0d valid", i), 32'(valid), 32'(v[i].e_vld));
      chk($sformatf("row%0d hazard", i), 32'(hazard), 32'(v[i].e_haz));
    end

    // Load-use: lw rt=4 followed by a consumer of r4
    w = zv(); w.mr = 1; w.rw = 1; w.m2r = 1; w.rs = 1; w.rt = 4; w.alusrc = 1; w.imm = 8; w.rsd = 32'h100;
    u = zv(); u.rs = 4; u.rt = 2; u.rd = 3; u.regdst = 1; u.rw = 1; u.aluop = 2'b10; u.funct = 6'b100000; u.rsd = 5;
    drive(w); step();
    drive(u); #1;
    chk("lu hazard rs", 32'(hazard), 32'h1);
    chk("lu memread", 32'(mr_out), 32'h1);
    step();
    chk("lu bubble valid", 32'(valid), 32'h0);
    chk("lu bubble regwrite", 32'(rw_out), 32'h0);
    chk("lu hazard cleared", 32'(hazard), 32'h0);
    step();
    chk("lu reissue valid", 32'(valid), 32'h1);
    chk("lu reissue rdaddr", 32'(rd_out), 32'h3);
    chk("lu reissue data1", data1, 32'h5);
    chk("lu reissue hazard", 32'(hazard), 32'h0);

    // RT-only match, then hold takes priority over the hazard bubble
    drive(w); step();
    u.rs = 1; u.rt = 4; drive(u); #1;
    chk("lu hazard rt", 32'(hazard), 32'h1);
    hold = 1; step();
    chk("lu held valid", 32'(valid), 32'h1);
    chk("lu held memread", 32'(mr_out), 32'h1);
    chk("lu held hazard", 32'(hazard), 32'h1);
    hold = 0; step();
    chk("lu after hold valid", 32'(valid), 32'h0);

    // Hold for 3 cycles with changing inputs, then flush while held
    x = zv(); x.rs = 7; x.rsd = 32'h100; x.rt = 8; x.rtd = 32'h200; x.rd = 10; x.regdst = 1;
    x.aluop = 2'b10; x.funct = 6'b100000; x.rw = 1;
    drive(x); step();
    chk("hold capture data1", data1, 32'h100);
    hold = 1;
    for (int c = 0; c < 3; c++) begin
      u = zv(); u.rs = 5'(c + 11); u.rsd = 32'(c + 32'h300); u.rt = 5'(c + 14); u.rtd = 32'h999;
      u.rd = 5'(c + 20); u.regdst = 1; u.aluop = 2'b10; u.funct = 6'b100010; u.mr = 1;
      drive(u); step();
      chk($sformatf("hold%0d data1", c), data1, 32'h100);
      chk($sformatf("hold%0d data2", c), data2, 32'h200);
      chk($sformatf("hold%0d rdaddr", c), 32'(rd_out), 32'd10);
      chk($sformatf("hold%0d aluctrl", c), 32'(alu_ctrl), 32'h2);
      chk($sformatf("hold%0d valid", c), 32'(valid), 32'h1);
    end
    exmem_we = 1; exmem_addr = 7; exmem_data = 32'hDEAD; #1;
    chk("hold fwd tracks", data1, 32'hDEAD);
    flush = 1; step();
    chk_bubble("flush+hold");
    flush = 0; hold = 0;

    // Reset mid-stream discards the captured instruction
    drive(x); step();
    chk("midrst pre valid", 32'(valid), 32'h1);
    rst = 1; step(); rst = 0;
    chk_bubble("midrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
